input_pulse_countdown_ctrl: RTL and testbench

Controller that turns one asynchronous user input into clean single-cycle pulses and uses them to sequence a 4-bit down counter. Chain: two-flop synchronizer, then optional debounce filter, then press/release FSM, then counter control with load, terminal and wrap handling. It sits between a board switch/key and the display or counter datapath, and replaces ad-hoc edge logic.

---
 rtl/input_pulse_countdown_ctrl.sv | 120 ++++++++++++
 tb/tb_input_pulse_countdown_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/input_pulse_countdown_ctrl.sv
// Async key input -> 2-flop sync -> optional debounce -> press FSM -> 4-bit down counter.
// Define INPUT_DEBOUNCE_EN to insert the DEB_CYCLES debounce filter ahead of the FSM.
module input_pulse_countdown_ctrl #(
  parameter int unsigned      WIDTH      = 4,
  parameter logic [WIDTH-1:0] START      = 4'hF,
  parameter int unsigned      WRAP       = 1,
  parameter int unsigned      DEB_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             pulse,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  logic             s1_q, s1_d, s2_q, s2_d;
  logic             lvl;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             done_q, done_d;

  always_comb begin
    s1_d = in;
    s2_d = s1_q;
  end

`ifdef INPUT_DEBOUNCE_EN
  logic       lvl_q, lvl_d;
  logic [3:0] deb_q, deb_d;

  // The level only follows s2 after DEB_CYCLES consecutive disagreeing samples.
  always_comb begin
    lvl_d = lvl_q;
    deb_d = '0;
    if (s2_q != lvl_q) begin
      if (deb_q + 4'd1 == 4'(DEB_CYCLES)) begin
        lvl_d = s2_q;
        deb_d = '0;
      end else begin
        deb_d = deb_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lvl_q <= 1'b0;
      deb_q <= '0;
    end else begin
      lvl_q <= lvl_d;
      deb_q <= deb_d;
    end
  end

  assign lvl = lvl_q;
`else
  logic unused_deb;
  assign unused_deb = (DEB_CYCLES == 0);
  assign lvl        = s2_q;
`endif

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = lvl ? PULSE : IDLE;
      PULSE:   state_d = lvl ? HOLD  : IDLE;
      HOLD:    state_d = lvl ? HOLD  : IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign pulse = (state_q == PULSE);

  // Load wins over a coincident pulse; that pulse is simply lost.
  always_comb begin
    count_d = count_q;
    done_d  = 1'b0;
    if (load) begin
      count_d = load_val;
    end else if (pulse) begin
      if (count_q != '0) begin
        count_d = count_q - WIDTH'(1);
        done_d  = (count_q == WIDTH'(1));
      end else if (WRAP != 0) begin
        count_d = START;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= IDLE;
      count_q <= START;
      done_q  <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);
  assign done  = done_q;

endmodule

// File: tb/tb_input_pulse_countdown_ctrl.sv
// Bench: directed cycle table for the multi-cycle corner cases, then random stimulus
// against an edge-detect / integer-arithmetic reference model.
module tb_input_pulse_countdown_ctrl;

  localparam int unsigned W      = 4;
  localparam int unsigned START  = 15;
  localparam int unsigned WRAP   = 1;
  localparam int unsigned TB_DEB = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         pulse;
  logic [W-1:0] count;
  logic         zero;
  logic         done;

  int n_cmp = 0;
  int n_bad = 0;

  input_pulse_countdown_ctrl #(
    .WIDTH(W), .START(4'hF), .WRAP(WRAP), .DEB_CYCLES(TB_DEB)
  ) dut (
    .clk(clk), .rst(rst), .in(in), .load(load), .load_val(load_val),
    .pulse(pulse), .count(count), .zero(zero), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: pulse is the registered rising edge of the filtered level.
  int m_s1, m_s2, m_lvl, m_dc, m_prev, m_pulse, m_count, m_done;

  task automatic model_step();
    int lvl_now;
    if (!rst) begin
      m_s1 = 0; m_s2 = 0; m_lvl = 0; m_dc = 0; m_prev = 0;
      m_pulse = 0; m_count = START; m_done = 0;
      return;
    end
`ifdef INPUT_DEBOUNCE_EN
    lvl_now = m_lvl;
`else
    lvl_now = m_s2;
`endif
    m_done = 0;
    if (load) m_count = int'(load_val);
    else if (m_pulse != 0) begin
      if (m_count > 0) begin
        m_done  = (m_count == 1) ? 1 : 0;
        m_count = m_count - 1;
      end else m_count = (WRAP != 0) ? START : 0;
    end
`ifdef INPUT_DEBOUNCE_EN
    if (m_s2 != m_lvl) begin
      m_dc++;
      if (m_dc == TB_DEB) begin m_lvl = m_s2; m_dc = 0; end
    end else m_dc = 0;
`endif
    m_pulse = (lvl_now != 0 && m_prev == 0) ? 1 : 0;
    m_prev  = lvl_now;
    m_s2    = m_s1;
    m_s1    = int'(in);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step_and_model(input string tag);
    model_step();
    @(posedge clk);
    #1;
    chk({tag, " model pulse"}, int'(pulse), m_pulse);
    chk({tag, " model count"}, int'(count), m_count);
    chk({tag, " model done"},  int'(done),  m_done);
    chk({tag, " model zero"},  int'(zero),  (m_count == 0) ? 1 : 0);
  endtask

  typedef struct {
    logic         rst, in, ld;
    logic [W-1:0] lv;
    logic         ep;
    logic [W-1:0] ec;
    logic         ed;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(int r, int i, int l, int lv, int ep, int ec, int ed);
    vec_t x;
    x.rst = r[0]; x.in = i[0]; x.ld = l[0]; x.lv = lv[W-1:0];
    x.ep  = ep[0]; x.ec = ec[W-1:0]; x.ed = ed[0];
    return x;
  endfunction

  initial begin
    // Reset, then a 4-cycle press: one pulse two edges after the rising sample.
    tbl.push_back(v(0,0,0,0, 0,15,0)); tbl.push_back(v(0,0,0,0, 0,15,0));
    tbl.push_back(v(1,1,0,0, 0,15,0)); tbl.push_back(v(1,1,0,0, 0,15,0));
    tbl.push_back(v(1,1,0,0, 1,15,0)); tbl.push_back(v(1,1,0,0, 0,14,0));
    tbl.push_back(v(1,0,0,0, 0,14,0)); tbl.push_back(v(1,0,0,0, 0,14,0));
    tbl.push_back(v(1,0,0,0, 0,14,0));
    // Re-press pattern 1,1,1,1,0,0,0,1,1,1,0,1,0 after a fresh reset.
    tbl.push_back(v(0,0,0,0, 0,15,0)); tbl.push_back(v(0,0,0,0, 0,15,0));
    tbl.push_back(v(1,1,0,0, 0,15,0)); tbl.push_back(v(1,1,0,0, 0,15,0));
    tbl.push_back(v(1,1,0,0, 1,15,0)); tbl.push_back(v(1,1,0,0, 0,14,0));
    tbl.push_back(v(1,0,0,0, 0,14,0)); tbl.push_back(v(1,0,0,0, 0,14,0));
    tbl.push_back(v(1,0,0,0, 0,14,0)); tbl.push_back(v(1,1,0,0, 0,14,0));
    tbl.push_back(v(1,1,0,0, 0,14,0)); tbl.push_back(v(1,1,0,0, 1,14,0));
    tbl.push_back(v(1,0,0,0, 0,13,0)); tbl.push_back(v(1,1,0,0, 0,13,0));
    tbl.push_back(v(1,0,0,0, 0,13,0)); tbl.push_back(v(1,0,0,0, 1,13,0));
    tbl.push_back(v(1,0,0,0, 0,12,0)); tbl.push_back(v(1,0,0,0, 0,12,0));
    // Terminal: load 2, presses give 1, 0 (done), then wrap to 15 without done.
    tbl.push_back(v(1,0,1,2, 0,2,0));
    tbl.push_back(v(1,1,0,0, 0,2,0));  tbl.push_back(v(1,0,0,0, 0,2,0));
    tbl.push_back(v(1,0,0,0, 1,2,0));  tbl.push_back(v(1,0,0,0, 0,1,0));
    tbl.push_back(v(1,0,0,0, 0,1,0));
    tbl.push_back(v(1,1,0,0, 0,1,0));  tbl.push_back(v(1,0,0,0, 0,1,0));
    tbl.push_back(v(1,0,0,0, 1,1,0));  tbl.push_back(v(1,0,0,0, 0,0,1));
    tbl.push_back(v(1,0,0,0, 0,0,0));
    tbl.push_back(v(1,1,0,0, 0,0,0));  tbl.push_back(v(1,0,0,0, 0,0,0));
    tbl.push_back(v(1,0,0,0, 1,0,0));  tbl.push_back(v(1,0,0,0, 0,15,0));
    tbl.push_back(v(1,0,0,0, 0,15,0));
    // Load of 9 on the same edge the pulse is seen: no decrement, no done.
    tbl.push_back(v(1,1,0,0, 0,15,0)); tbl.push_back(v(1,0,0,0, 0,15,0));
    tbl.push_back(v(1,0,0,0, 1,15,0)); tbl.push_back(v(1,0,1,9, 0,9,0));
    tbl.push_back(v(1,0,0,0, 0,9,0));
    // Reset while held: count back to START, then a fresh pulse.
    tbl.push_back(v(1,1,0,0, 0,9,0));  tbl.push_back(v(1,1,0,0, 0,9,0));
    tbl.push_back(v(1,1,0,0, 1,9,0));  tbl.push_back(v(1,1,0,0, 0,8,0));
    tbl.push_back(v(1,1,0,0, 0,8,0));  tbl.push_back(v(0,1,0,0, 0,15,0));
    tbl.push_back(v(1,1,0,0, 0,15,0)); tbl.push_back(v(1,1,0,0, 0,15,0));
    tbl.push_back(v(1,1,0,0, 1,15,0)); tbl.push_back(v(1,1,0,0, 0,14,0));
    tbl.push_back(v(1,0,0,0, 0,14,0)); tbl.push_back(v(1,0,0,0, 0,14,0));
    tbl.push_back(v(1,0,0,0, 0,14,0));

    @(negedge clk);
`ifndef INPUT_DEBOUNCE_EN
    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; in = tbl[i].in; load = tbl[i].ld; load_val = tbl[i].lv;
      step_and_model($sformatf("row%0d", i));
      chk($sformatf("row%0d pulse", i), int'(pulse), int'(tbl[i].ep));
      chk($sformatf("row%0d count", i), int'(count), int'(tbl[i].ec));
      chk($sformatf("row%0d done", i),  int'(done),  int'(tbl[i].ed));
      chk($sformatf("row%0d zero", i),  int'(zero),  (tbl[i].ec == 0) ? 1 : 0);
    end
`else
    rst = 1'b0;
    step_and_model("rst0");
    step_and_model("rst1");
`endif

    // Random phase: sticky input level, occasional loads and resets.
    rst = 1'b1; in = 1'b0; load = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) in = ~in;
      load     = ($urandom_range(0, 15) == 0);
      load_val = W'($urandom_range(0, 3) == 0 ? $urandom_range(0, 2) : $urandom_range(0, 15));
      rst      = ($urandom_range(0, 127) != 0);
      step_and_model($sformatf("rnd%0d", c));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
